ctxt_word_packer: RTL

//   Downstream consumer of stream_cipher output. Collects one ctxt byte per dout_valid pulse and

---
 rtl/cipher_pkg.sv | 20 ++
 rtl/packer_fifo.sv | 64 ++++++
 rtl/ctxt_word_packer.sv | 91 +++++++++
 3 files changed

// File: rtl/cipher_pkg.sv
// Shared types for the cipher datapath: byte/word geometry and the packed-word FIFO entry.
package cipher_pkg;

   localparam int BYTE_W     = 8;
   localparam int WORD_BYTES = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_entry_t;

   // Lane-enable mask for n_bytes valid lanes, contiguous from lane 0 (n_bytes = 0..4).
   function automatic logic [3:0] keep_mask(input logic [2:0] n_bytes);
      logic [4:0] mask;
      mask = (5'd1 << n_bytes) - 5'd1;
      return mask[3:0];
   endfunction

endpackage

// File: rtl/packer_fifo.sv
// Synchronous FIFO of packed words with a registered head (no fall-through).
// Pointers carry one extra wrap bit; the head register holds the entry at rd_ptr.
module packer_fifo
   import cipher_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  word_entry_t push_entry,
   input  logic        pop,
   output word_entry_t head,
   output logic        head_valid,
   output logic        full,
   output logic        empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   word_entry_t mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] rd_next;
   logic        do_pop;
   logic        do_push;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_pop  = pop && head_valid;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign rd_next = do_pop ? (rd_ptr + PTR_ONE) : rd_ptr;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_entry;
      end
   end

   // The head is refreshed from storage only for entries written on an earlier edge,
   // which gives the one-cycle push-to-valid latency and keeps word_ready off any comb path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         head       <= '0;
         head_valid <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         rd_ptr <= rd_next;
         if (rd_next != wr_ptr) begin
            head       <= mem[rd_next[AW-1:0]];
            head_valid <= 1'b1;
         end else begin
            head_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ctxt_word_packer.sv
// Packs cipher output bytes little-endian into 32-bit words and queues them for a
// valid/ready consumer. The byte source cannot stall, so a full queue drops and flags overflow.
module ctxt_word_packer
   import cipher_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ctxt_char,
   input  logic        dout_valid,
   input  logic        in_last,
   input  logic        flush,
   output logic [31:0] word_data,
   output logic [3:0]  word_keep,
   output logic        word_last,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        overflow
);

   logic [1:0]  cnt;
   logic [31:0] acc;
   logic [31:0] merged;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   word_entry_t entry;
   word_entry_t head;

   // Build the entry for this cycle: a byte closes the word on lane 3, in_last or flush;
   // a lone flush closes whatever partial word is pending.
   always_comb begin
      merged = acc;
      merged[{cnt, 3'b000} +: BYTE_W] = ctxt_char;
      push  = 1'b0;
      entry = '0;
      if (dout_valid) begin
         entry.data = merged;
         entry.keep = keep_mask({1'b0, cnt} + 3'd1);
         entry.last = in_last || flush;
         push       = (cnt == 2'd3) || in_last || flush;
      end else if (flush && (cnt != 2'd0)) begin
         entry.data = acc;
         entry.keep = keep_mask({1'b0, cnt});
         entry.last = 1'b1;
         push       = 1'b1;
      end
   end

   assign pop = word_valid && word_ready && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         acc      <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            cnt <= '0;
            acc <= '0;
         end else if (dout_valid) begin
            cnt <= cnt + 2'd1;
            acc <= merged;
         end
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   packer_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (entry),
      .pop        (pop),
      .head       (head),
      .head_valid (word_valid),
      .full       (full),
      .empty      (empty)
   );

   assign word_data = head.data;
   assign word_keep = head.keep;
   assign word_last = head.last;

endmodule
